sent_frame_sched: RTL and testbench
===================================

Name: sent_frame_sched

Overview:
- Per-channel frame scheduler between the SENT UDP config decoder and the per-channel SENT frame generators.
- Accepts decoded frame writes tagged with a channel index and holds one pending frame per channel (newest wins).
- Dispatches pending frames round-robin to channels whose frame FIFO is not full, over one shared data bus with per-channel valid strobes.
- Replaces the broadcast frame-valid fan-out so FIFO back-pressure is honoured per channel.

Parameters:
- SENT_NUM, 4, number of SENT channels (1..16).
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  input  1  module clock.
- rst  input  1  asynchronous reset, active-high.
- in_frame_vld  input  1  frame write strobe, one cycle per frame.
- in_frame_channel  input  8  target channel index.
- in_frame_data  input  32  frame payload.
- sent_fifo_full  input  SENT_NUM  per-channel FIFO full flag.
- sent_fifo_empty  input  SENT_NUM  per-channel FIFO empty flag.
- sent_frame_vld  output  SENT_NUM  one-hot dispatch strobe, one cycle.
- sent_frame_data  output  32  dispatched payload, valid with the strobe.
- pending  output  SENT_NUM  per-channel pending-slot valid.
- ovwr_cnt  output  CNT_W  frames overwritten before dispatch (saturating).
- inval_cnt  output  CNT_W  writes with channel >= SENT_NUM (saturating).

Behaviour:
- Reset: all outputs 0; all pending slots cleared; RR pointer = SENT_NUM-1, so channel 0 has first priority; FSM in S_IDLE. Reset mid-dispatch drops the strobe immediately (asynchronous) and discards all pending frames.
- Write path: in_frame_vld with channel c < SENT_NUM stores the data in slot c and sets pending[c] at the next edge.
  - If pending[c] was already 1 and slot c is not being dispatched that edge: data is overwritten and ovwr_cnt increments.
  - If channel >= SENT_NUM: write is discarded and inval_cnt increments.
- Eligibility: channel i is eligible when pending[i]=1 and sent_fifo_full[i]=0.
- FSM:
  - S_IDLE: if any channel is eligible, latch the first eligible channel scanning upward from pointer+1 with wrap, then go to S_GRANT. Otherwise stay in S_IDLE.
  - S_GRANT (1 cycle): sent_frame_vld[g]=1 and sent_frame_data=slot g, both registered. pending[g] clears at the end of this cycle. Pointer updates to g. Next state is S_WAIT.
  - S_WAIT (1 cycle): lets the FIFO full flag settle. Next state is S_IDLE.
- Latency: a write sampled at edge E0 produces the strobe high in the cycle following E1, i.e. 2 cycles after the write cycle, for an idle, non-full channel. Maximum throughput is 1 frame per 3 cycles.
- Simultaneous write to channel g while S_GRANT dispatches g: the old data is dispatched, the new data is stored, pending[g] stays 1, and ovwr_cnt does not increment.
- A full flag rising after the grant is latched does not cancel the dispatch. The downstream FIFO drops the frame.
- Counters stop at 2^CNT_W-1.
- sent_frame_data holds its last value when no strobe is active.

Optional Feature:
- SENT_REPEAT_EN: when defined, a channel that has no pending frame, has sent_fifo_empty=1, and has dispatched at least once since reset is also eligible, with lower priority than any channel with pending=1. Its last dispatched frame is re-sent, giving continuous SENT output. Repeats do not touch the counters.
- When undefined: the output idles after the last frame and the block keeps no repeat state.

Test Plan:
- Reset, then write ch1 data 0x12345678 with full=0 -> sent_frame_vld=4'b0010 two cycles later with data 0x12345678, held 1 cycle; pending[1] then 0.
- Writes to ch0, ch2, ch3 on consecutive cycles -> strobes appear in order ch0, ch2, ch3, spaced 3 cycles apart.
- Hold full[2]=1 and write ch2 twice (0xA, then 0xB) -> no strobe and ovwr_cnt=1. Release full -> a single strobe with 0xB.
- Write channel 0x07 with SENT_NUM=4 -> inval_cnt=1, no strobe, pending unchanged.
- Write ch1 in the same cycle ch1 is in S_GRANT -> old data is dispatched, new data dispatched 3 cycles later, ovwr_cnt unchanged.
- With SENT_REPEAT_EN defined, after a ch0 dispatch of 0x55 hold empty[0]=1 -> ch0 is re-strobed with 0x55 every 3 cycles. A write to ch3 pre-empts the next repeat.

Source files
------------

// File: rtl/sent_frame_sched.sv
// rtl/sent_frame_sched.sv - round-robin per-channel SENT frame scheduler with one pending slot per channel
// Optional feature macro: SENT_REPEAT_EN (re-send last frame to idle channels with an empty FIFO)
module sent_frame_sched #(
    parameter int SENT_NUM = 4,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_frame_vld,
    input  logic [7:0]          in_frame_channel,
    input  logic [31:0]         in_frame_data,
    input  logic [SENT_NUM-1:0] sent_fifo_full,
    input  logic [SENT_NUM-1:0] sent_fifo_empty,
    output logic [SENT_NUM-1:0] sent_frame_vld,
    output logic [31:0]         sent_frame_data,
    output logic [SENT_NUM-1:0] pending,
    output logic [CNT_W-1:0]    ovwr_cnt,
    output logic [CNT_W-1:0]    inval_cnt
);

    localparam int IDX_W = (SENT_NUM > 1) ? $clog2(SENT_NUM) : 1;
    localparam int CW    = IDX_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic [SENT_NUM-1:0] pending_q, pending_d;
    logic [SENT_NUM-1:0] vld_q, vld_d;
    logic [31:0]         data_q, data_d;
    logic [CNT_W-1:0]    ovwr_q, inval_q;
    logic [31:0]         slot_q [SENT_NUM];

    logic                wr_ok;
    logic                wr_inval;
    logic [IDX_W-1:0]    wr_idx;
    logic [SENT_NUM-1:0] wr_mask;
    logic [SENT_NUM-1:0] grant_oh;
    logic [SENT_NUM-1:0] disp_mask;
    logic                dispatching;
    logic                ovwr_inc;
    logic [SENT_NUM-1:0] elig_pend;
    logic [CW-1:0]       pick_pend;
    logic [CW-1:0]       pick;
    logic                pick_found;
    logic [IDX_W-1:0]    pick_idx;

    // Returns {found, index} of the first set mask bit scanning upward from ptr+1 with wrap.
    function automatic logic [CW-1:0] rr_pick(input logic [SENT_NUM-1:0] mask,
                                              input logic [IDX_W-1:0]    ptr);
        logic [CW-1:0] cand;
        logic [CW-1:0] res;
        res = '0;
        for (int k = SENT_NUM; k >= 1; k--) begin
            cand = {1'b0, ptr} + CW'(k);
            if (cand >= CW'(SENT_NUM)) begin
                cand = cand - CW'(SENT_NUM);
            end
            if (mask[cand[IDX_W-1:0]]) begin
                res = {1'b1, cand[IDX_W-1:0]};
            end
        end
        return res;
    endfunction

    assign wr_ok    = in_frame_vld && (in_frame_channel < 8'(SENT_NUM));
    assign wr_inval = in_frame_vld && !(in_frame_channel < 8'(SENT_NUM));
    assign wr_idx   = in_frame_channel[IDX_W-1:0];
    assign wr_mask  = wr_ok ? (SENT_NUM'(1) << wr_idx) : '0;

    assign grant_oh    = SENT_NUM'(1) << grant_q;
    assign dispatching = (state_q == S_GRANT);
    assign disp_mask   = dispatching ? grant_oh : '0;

    // A write landing on the slot being dispatched is a fresh frame, not an overwrite.
    assign ovwr_inc  = wr_ok && pending_q[wr_idx] && !(dispatching && (grant_q == wr_idx));
    assign pending_d = (pending_q & ~disp_mask) | wr_mask;

    assign elig_pend = pending_q & ~sent_fifo_full;
    assign pick_pend = rr_pick(elig_pend, ptr_q);

`ifdef SENT_REPEAT_EN
    logic [SENT_NUM-1:0] has_sent_q, has_sent_d;
    logic [SENT_NUM-1:0] elig_rep;
    logic [CW-1:0]       pick_rep;

    // With pending clear, slot_q still holds the last dispatched frame, so repeats reuse it.
    assign elig_rep   = ~pending_q & sent_fifo_empty & has_sent_q & ~sent_fifo_full;
    assign pick_rep   = rr_pick(elig_rep, ptr_q);
    assign pick       = pick_pend[CW-1] ? pick_pend : pick_rep;
    assign has_sent_d = has_sent_q | disp_mask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            has_sent_q <= '0;
        end else begin
            has_sent_q <= has_sent_d;
        end
    end
`else
    logic unused_empty;

    assign pick         = pick_pend;
    assign unused_empty = ^sent_fifo_empty;
`endif

    assign pick_found = pick[CW-1];
    assign pick_idx   = pick[IDX_W-1:0];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        vld_d   = '0;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    vld_d   = SENT_NUM'(1) << pick_idx;
                    // Same-edge write to the chosen channel supersedes the stored frame.
                    if (wr_ok && (wr_idx == pick_idx)) begin
                        data_d = in_frame_data;
                    end else begin
                        data_d = slot_q[pick_idx];
                    end
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                ptr_d   = grant_q;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= IDX_W'(SENT_NUM - 1);
            grant_q   <= '0;
            pending_q <= '0;
            vld_q     <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            pending_q <= pending_d;
            vld_q     <= vld_d;
            data_q    <= data_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SENT_NUM; i++) begin
                slot_q[i] <= '0;
            end
        end else if (wr_ok) begin
            slot_q[wr_idx] <= in_frame_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovwr_q  <= '0;
            inval_q <= '0;
        end else begin
            if (ovwr_inc && (ovwr_q != {CNT_W{1'b1}})) begin
                ovwr_q <= ovwr_q + CNT_W'(1);
            end
            if (wr_inval && (inval_q != {CNT_W{1'b1}})) begin
                inval_q <= inval_q + CNT_W'(1);
            end
        end
    end

    assign sent_frame_vld  = vld_q;
    assign sent_frame_data = data_q;
    assign pending         = pending_q;
    assign ovwr_cnt        = ovwr_q;
    assign inval_cnt       = inval_q;

endmodule

// File: tb/tb_sent_frame_sched.sv
// tb/tb_sent_frame_sched.sv - randomized and directed checks of sent_frame_sched against a behavioural model
module tb_sent_frame_sched;

    localparam int N    = 4;
    localparam int CMAX = 65535;

    logic          clk;
    logic          rst;
    logic          in_frame_vld;
    logic [7:0]    in_frame_channel;
    logic [31:0]   in_frame_data;
    logic [N-1:0]  sent_fifo_full;
    logic [N-1:0]  sent_fifo_empty;
    logic [N-1:0]  sent_frame_vld;
    logic [31:0]   sent_frame_data;
    logic [N-1:0]  pending;
    logic [15:0]   ovwr_cnt;
    logic [15:0]   inval_cnt;

    int tests  = 0;
    int errors = 0;

    sent_frame_sched #(.SENT_NUM(N), .CNT_W(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_frame_vld     (in_frame_vld),
        .in_frame_channel (in_frame_channel),
        .in_frame_data    (in_frame_data),
        .sent_fifo_full   (sent_fifo_full),
        .sent_fifo_empty  (sent_fifo_empty),
        .sent_frame_vld   (sent_frame_vld),
        .sent_frame_data  (sent_frame_data),
        .pending          (pending),
        .ovwr_cnt         (ovwr_cnt),
        .inval_cnt        (inval_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: pending frames per channel, a scheduler that is busy for
    // three cycles per dispatch (strobe, settle, rescan) and round-robin order.
    bit          m_pend [N];
    logic [31:0] m_slot [N];
    bit          m_sent [N];
    int          m_busy;
    int          m_ptr;
    int          m_g;
    logic [N-1:0] m_vld;
    logic [31:0] m_data;
    int          m_ovwr;
    int          m_inval;

    function automatic int scan(input bit rep);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (!sent_fifo_full[c]) begin
                if (!rep && m_pend[c]) return c;
                if (rep && !m_pend[c] && sent_fifo_empty[c] && m_sent[c]) return c;
            end
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0;
            m_slot[i] = '0;
            m_sent[i] = 0;
        end
        m_busy  = 0;
        m_ptr   = N - 1;
        m_g     = 0;
        m_vld   = '0;
        m_data  = '0;
        m_ovwr  = 0;
        m_inval = 0;
    endtask

    task automatic model_step();
        bit wr;
        int wc;
        int c;
        wc = int'(in_frame_channel);
        wr = in_frame_vld && (wc < N);
        if (in_frame_vld && wc >= N && m_inval < CMAX) m_inval++;
        if (wr && m_pend[wc] && !(m_busy == 2 && m_g == wc) && m_ovwr < CMAX) m_ovwr++;
        if (m_busy == 0) begin
            c = scan(0);
`ifdef SENT_REPEAT_EN
            if (c < 0) c = scan(1);
`endif
            if (c >= 0) begin
                m_g    = c;
                m_vld  = N'(1) << c;
                m_data = (wr && wc == c) ? in_frame_data : m_slot[c];
                m_busy = 2;
            end
        end else if (m_busy == 2) begin
            m_pend[m_g] = 0;
            m_sent[m_g] = 1;
            m_ptr       = m_g;
            m_vld       = '0;
            m_busy      = 1;
        end else begin
            m_busy = 0;
        end
        if (wr) begin
            m_slot[wc] = in_frame_data;
            m_pend[wc] = 1;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            logic [N-1:0] pv;
            for (int i = 0; i < N; i++) pv[i] = m_pend[i];
            chk("model_vld",     32'(sent_frame_vld), 32'(m_vld));
            chk("model_data",    sent_frame_data,     m_data);
            chk("model_pending", 32'(pending),        32'(pv));
            chk("model_ovwr",    32'(ovwr_cnt),       32'(m_ovwr));
            chk("model_inval",   32'(inval_cnt),      32'(m_inval));
        end
    end

    task automatic step(input bit v, input int ch, input logic [31:0] d, input logic [N-1:0] full);
        @(posedge clk);
        #1;
        in_frame_vld     = v;
        in_frame_channel = 8'(ch);
        in_frame_data    = d;
        sent_fifo_full   = full;
        @(negedge clk);
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1;
        in_frame_vld    = 1'b0;
        sent_fifo_full  = '0;
        sent_fifo_empty = '0;
        rst             = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nstb;
        logic [31:0] last;
        bit seen;
        rst              = 1'b1;
        in_frame_vld     = 1'b0;
        in_frame_channel = '0;
        in_frame_data    = '0;
        sent_fifo_full   = '0;
        sent_fifo_empty  = '0;
        #3;
        chk("reset_vld",   32'(sent_frame_vld), 32'h0);
        chk("reset_data",  sent_frame_data,     32'h0);
        chk("reset_pend",  32'(pending),        32'h0);
        chk("reset_ovwr",  32'(ovwr_cnt),       32'h0);
        chk("reset_inval", 32'(inval_cnt),      32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single frame to ch1: strobe two cycles after the write cycle, for one cycle.
        reset_dut();
        step(1, 1, 32'h12345678, '0);
        chk("t1_s0_vld", 32'(sent_frame_vld), 32'h0);
        step(0, 0, '0, '0);
        chk("t1_s1_vld", 32'(sent_frame_vld), 32'h0);
        step(0, 0, '0, '0);
        chk("t1_s2_vld",  32'(sent_frame_vld), 32'h2);
        chk("t1_s2_data", sent_frame_data,     32'h12345678);
        step(0, 0, '0, '0);
        chk("t1_s3_vld",  32'(sent_frame_vld), 32'h0);
        chk("t1_s3_pend", 32'(pending[1]),     32'h0);

        // Back-to-back writes dispatched in order, 3 cycles apart.
        reset_dut();
        for (int k = 0; k < 9; k++) begin
            int ch;
            ch = (k == 0) ? 0 : (k == 1) ? 2 : 3;
            step(k < 3, ch, 32'hA0 + 32'(ch), '0);
            if (k == 2) begin
                chk("t2_ch0_vld",  32'(sent_frame_vld), 32'h1);
                chk("t2_ch0_data", sent_frame_data,     32'hA0);
            end
            if (k == 5) begin
                chk("t2_ch2_vld",  32'(sent_frame_vld), 32'h4);
                chk("t2_ch2_data", sent_frame_data,     32'hA2);
            end
            if (k == 8) begin
                chk("t2_ch3_vld",  32'(sent_frame_vld), 32'h8);
                chk("t2_ch3_data", sent_frame_data,     32'hA3);
            end
        end

        // Full channel: overwrite counted, newest frame sent once after release.
        reset_dut();
        step(1, 2, 32'hA, 4'b0100);
        step(1, 2, 32'hB, 4'b0100);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, '0, 4'b0100);
            chk("t3_blocked_vld", 32'(sent_frame_vld), 32'h0);
        end
        chk("t3_ovwr", 32'(ovwr_cnt), 32'd1);
        nstb = 0;
        last = '0;
        for (int k = 0; k < 6; k++) begin
            step(0, 0, '0, '0);
            if (sent_frame_vld != '0) begin
                nstb++;
                last = sent_frame_data;
                chk("t3_vld", 32'(sent_frame_vld), 32'h4);
            end
        end
        chk("t3_nstrobe", 32'(nstb), 32'd1);
        chk("t3_data",    last,      32'hB);

        // Out-of-range channel.
        reset_dut();
        step(1, 7, 32'hDEAD, '0);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, '0, '0);
            chk("t4_vld", 32'(sent_frame_vld), 32'h0);
        end
        chk("t4_inval", 32'(inval_cnt), 32'd1);
        chk("t4_pend",  32'(pending),   32'h0);

        // Write to ch1 while ch1 is being granted.
        reset_dut();
        step(1, 1, 32'h111, '0);
        step(0, 0, '0, '0);
        step(1, 1, 32'h222, '0);
        chk("t5_old_vld",  32'(sent_frame_vld), 32'h2);
        chk("t5_old_data", sent_frame_data,     32'h111);
        step(0, 0, '0, '0);
        chk("t5_pend", 32'(pending[1]), 32'h1);
        step(0, 0, '0, '0);
        chk("t5_gap_vld", 32'(sent_frame_vld), 32'h0);
        step(0, 0, '0, '0);
        chk("t5_new_vld",  32'(sent_frame_vld), 32'h2);
        chk("t5_new_data", sent_frame_data,     32'h222);
        chk("t5_ovwr",     32'(ovwr_cnt),       32'd0);

        // Randomized traffic with a mid-dispatch asynchronous reset.
        reset_dut();
        for (int it = 0; it < 3000; it++) begin
            bit v;
            int ch;
            v  = ($urandom_range(0, 2) == 0);
            ch = ($urandom_range(0, 15) == 0) ? int'($urandom_range(4, 255)) : int'($urandom_range(0, 3));
            sent_fifo_empty = N'($urandom);
            step(v, ch, $urandom, N'($urandom & $urandom));
            if (it == 1500) begin
                step(1, 0, 32'hCAFE0000, '0);
                seen = 0;
                for (int w = 0; w < 20 && !seen; w++) begin
                    step(0, 0, '0, '0);
                    if (sent_frame_vld != '0) seen = 1;
                end
                chk("ar_strobe_seen", 32'(seen), 32'd1);
                #2;
                rst = 1'b1;
                #1;
                chk("ar_vld",   32'(sent_frame_vld), 32'h0);
                chk("ar_pend",  32'(pending),        32'h0);
                chk("ar_ovwr",  32'(ovwr_cnt),       32'h0);
                chk("ar_inval", 32'(inval_cnt),      32'h0);
                in_frame_vld = 1'b0;
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
        end

        step(0, 0, '0, '0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
